// File: rtl/lpm_bustri_seq_if.sv
// Bus-side bundle for lpm_bustri_seq: transmit stream, read requests,
// tri-state buffer controls and the sampled bus value.
interface lpm_bustri_seq_if #(parameter int WIDTH = 8);
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             rx_req;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             enabledt;
  logic             enabletr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (output tx_valid, tx_data, rx_req, result,
                  input  tx_ready, rx_valid, rx_data, enabledt, enabletr, data, busy);
  modport slave  (input  tx_valid, tx_data, rx_req, result,
                  output tx_ready, rx_valid, rx_data, enabledt, enabletr, data, busy);
endinterface

// File: rtl/lpm_bustri_seq.sv
// Half-duplex tri-state bus sequencer: arbitrates transmit beats against reads,
// inserts turnaround cycles on direction changes and tracks read latency.
module lpm_bustri_seq #(
  parameter int lpm_width      = 8,
  parameter     lpm_type       = "lpm_bustri_seq",
  parameter     lpm_hint       = "UNUSED",
  parameter int lpm_turnaround = 1,
  parameter int lpm_rdlatency  = 2
) (
  input  logic            clock,
  input  logic            sclr,
  lpm_bustri_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_TX, S_TURN, S_RX} state_e;
  typedef enum logic [1:0] {D_NONE, D_TX, D_RX} dir_e;

  localparam int         PW        = lpm_rdlatency;
  localparam logic [3:0] TURN_LAST = 4'(lpm_turnaround - 1);

  state_e               state_q, state_d;
  dir_e                 lastdir_q, lastdir_d;
  logic                 tgt_rx_q, tgt_rx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [PW-1:0]        pipe_q, pipe_d;
  logic                 enabledt_q, enabletr_q, rx_valid_q;
  logic [lpm_width-1:0] data_q, rx_data_q;
  logic                 tx_acc, rd_iss, want_rx, direct;

  always_comb begin
    state_d   = state_q;
    lastdir_d = lastdir_q;
    tgt_rx_d  = tgt_rx_q;
    cnt_d     = cnt_q;
    tx_acc    = (state_q == S_TX) && bus.tx_valid;
    rd_iss    = (state_q == S_RX) && bus.rx_req;
    pipe_d    = (pipe_q << 1) | PW'(rd_iss);
    want_rx   = !bus.tx_valid;
    direct    = (lpm_turnaround == 0) || (lastdir_q == D_NONE) ||
                (lastdir_q == (want_rx ? D_RX : D_TX));
    unique case (state_q)
      S_IDLE: if (bus.tx_valid || bus.rx_req) begin
        if (direct) state_d = want_rx ? S_RX : S_TX;
        else begin
          state_d  = S_TURN;
          tgt_rx_d = want_rx;
          cnt_d    = TURN_LAST;
        end
      end
      S_TX: if (!bus.tx_valid) begin
        state_d   = S_IDLE;
        lastdir_d = D_TX;
      end
      S_TURN: if (cnt_q == '0) state_d = tgt_rx_q ? S_RX : S_TX;
              else cnt_d = cnt_q - 4'd1;
      // Hold RX (and enabletr) until the final in-flight read samples.
      S_RX: if (!bus.rx_req && pipe_d == '0) begin
        state_d   = S_IDLE;
        lastdir_d = D_RX;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q    <= S_IDLE;
      lastdir_q  <= D_NONE;
      tgt_rx_q   <= 1'b0;
      cnt_q      <= '0;
      pipe_q     <= '0;
      enabledt_q <= 1'b0;
      enabletr_q <= 1'b0;
      data_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      lastdir_q  <= lastdir_d;
      tgt_rx_q   <= tgt_rx_d;
      cnt_q      <= cnt_d;
      pipe_q     <= pipe_d;
      enabledt_q <= tx_acc;
      enabletr_q <= (state_d == S_RX);
      if (tx_acc) data_q <= bus.tx_data;
      rx_valid_q <= pipe_q[PW-1];
      if (pipe_q[PW-1]) rx_data_q <= bus.result;
    end
  end

  assign bus.tx_ready = (state_q == S_TX);
  assign bus.enabledt = enabledt_q;
  assign bus.enabletr = enabletr_q;
  assign bus.data     = data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = (state_q != S_IDLE) || enabledt_q || enabletr_q || (|pipe_q);
endmodule

// File: tb/tb_lpm_bustri_seq.sv
// Random and directed bench for lpm_bustri_seq: three parameterizations share
// one stimulus stream and are compared cycle-by-cycle against a reference model.
module tb_lpm_bustri_seq;
  localparam int W  = 8;
  localparam int NI = 3;
  localparam int M_IDLE = 0, M_TX = 1, M_TURN = 2, M_RX = 3;
  localparam int L_NONE = 0, L_TX = 1, L_RX = 2;

  logic         clk = 1'b0;
  logic         sclr, tx_valid, rx_req;
  logic [W-1:0] tx_data, result;
  always #5 clk = ~clk;

  lpm_bustri_seq_if #(.WIDTH(W)) b0 (), b1 (), b2 ();
  assign b0.tx_valid = tx_valid; assign b0.tx_data = tx_data;
  assign b0.rx_req   = rx_req;   assign b0.result  = result;
  assign b1.tx_valid = tx_valid; assign b1.tx_data = tx_data;
  assign b1.rx_req   = rx_req;   assign b1.result  = result;
  assign b2.tx_valid = tx_valid; assign b2.tx_data = tx_data;
  assign b2.rx_req   = rx_req;   assign b2.result  = result;

  lpm_bustri_seq #(.lpm_width(W), .lpm_turnaround(1), .lpm_rdlatency(2))
    u0 (.clock(clk), .sclr(sclr), .bus(b0.slave));
  lpm_bustri_seq #(.lpm_width(W), .lpm_turnaround(0), .lpm_rdlatency(1))
    u1 (.clock(clk), .sclr(sclr), .bus(b1.slave));
  lpm_bustri_seq #(.lpm_width(W), .lpm_turnaround(3), .lpm_rdlatency(5))
    u2 (.clock(clk), .sclr(sclr), .bus(b2.slave));

  function automatic int ta(input int k);
    ta = (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction
  function automatic int la(input int k);
    la = (k == 0) ? 2 : (k == 1) ? 1 : 5;
  endfunction

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: bus direction mode plus a queue of read sample times.
  int           m_st [NI], m_last [NI], m_tgt [NI], m_left [NI];
  logic         e_dt [NI], e_tr [NI], e_rxv [NI];
  logic [W-1:0] e_data [NI], e_rxd [NI];
  int           due [NI][$];
  int           cyc = 0;
  logic         armed = 1'b0;

  task automatic model(input int k, input logic rst, input logic iv, input logic [W-1:0] id,
                       input logic ir, input logic [W-1:0] res);
    logic acc, iss;
    int   want;
    if (rst) begin
      m_st[k] = M_IDLE; m_last[k] = L_NONE; m_tgt[k] = L_NONE; m_left[k] = 0;
      e_dt[k] = 0; e_tr[k] = 0; e_rxv[k] = 0; e_data[k] = '0; e_rxd[k] = '0;
      due[k].delete();
      return;
    end
    acc  = (m_st[k] == M_TX) && iv;
    iss  = (m_st[k] == M_RX) && ir;
    want = iv ? L_TX : L_RX;
    e_rxv[k] = 1'b0;
    if (due[k].size() > 0) begin
      if (due[k][0] == cyc) begin
        void'(due[k].pop_front());
        e_rxv[k] = 1'b1;
        e_rxd[k] = res;
      end
    end
    if (iss) due[k].push_back(cyc + la(k));
    case (m_st[k])
      M_IDLE: if (iv || ir) begin
        if (ta(k) == 0 || m_last[k] == L_NONE || m_last[k] == want)
          m_st[k] = (want == L_TX) ? M_TX : M_RX;
        else begin
          m_st[k] = M_TURN; m_left[k] = ta(k); m_tgt[k] = want;
        end
      end
      M_TX:   if (!iv) begin m_st[k] = M_IDLE; m_last[k] = L_TX; end
      M_TURN: begin
        m_left[k]--;
        if (m_left[k] == 0) m_st[k] = (m_tgt[k] == L_TX) ? M_TX : M_RX;
      end
      M_RX:   if (!ir && due[k].size() == 0) begin m_st[k] = M_IDLE; m_last[k] = L_RX; end
      default: ;
    endcase
    e_dt[k] = acc;
    if (acc) e_data[k] = id;
    e_tr[k] = (m_st[k] == M_RX);
  endtask

  // {tx_ready, enabledt, enabletr, data, rx_valid, rx_data, busy}
  function automatic logic [20:0] obs(input int k);
    case (k)
      0:       obs = {b0.tx_ready, b0.enabledt, b0.enabletr, b0.data, b0.rx_valid, b0.rx_data, b0.busy};
      1:       obs = {b1.tx_ready, b1.enabledt, b1.enabletr, b1.data, b1.rx_valid, b1.rx_data, b1.busy};
      default: obs = {b2.tx_ready, b2.enabledt, b2.enabletr, b2.data, b2.rx_valid, b2.rx_data, b2.busy};
    endcase
  endfunction

  task automatic check_all();
    logic [20:0] o;
    for (int k = 0; k < NI; k++) begin
      o = obs(k);
      chk($sformatf("u%0d.tx_ready", k), 32'(o[20]), 32'(m_st[k] == M_TX));
      chk($sformatf("u%0d.enabledt", k), 32'(o[19]), 32'(e_dt[k]));
      chk($sformatf("u%0d.enabletr", k), 32'(o[18]), 32'(e_tr[k]));
      chk($sformatf("u%0d.data", k),     32'(o[17:10]), 32'(e_data[k]));
      chk($sformatf("u%0d.rx_valid", k), 32'(o[9]), 32'(e_rxv[k]));
      chk($sformatf("u%0d.rx_data", k),  32'(o[8:1]), 32'(e_rxd[k]));
      chk($sformatf("u%0d.busy", k),     32'(o[0]),
          32'((m_st[k] != M_IDLE) || e_dt[k] || e_tr[k] || (due[k].size() != 0)));
      chk($sformatf("u%0d.excl", k),     32'(o[19] & o[18]), 32'd0);
    end
  endtask

  // Observations of u0 for the directed scenarios.
  logic         rec = 1'b0;
  logic [W-1:0] cap_dt [$];
  logic [W-1:0] cap_rx [$];
  int           n_tr, n_acc, first_tr, last_dt;
  logic         last_tr, last_busy;

  task automatic rec_start();
    rec = 1'b1; cap_dt.delete(); cap_rx.delete();
    n_tr = 0; n_acc = 0; first_tr = -1; last_dt = -1;
  endtask

  task automatic step(input logic rst, input logic iv, input logic [W-1:0] id,
                      input logic ir, input logic [W-1:0] res);
    @(negedge clk);
    if (armed) check_all();
    if (rec) begin
      if (b0.enabledt) begin cap_dt.push_back(b0.data); last_dt = cyc; end
      if (b0.rx_valid) cap_rx.push_back(b0.rx_data);
      if (b0.enabletr) begin n_tr++; if (first_tr < 0) first_tr = cyc; end
      last_tr = b0.enabletr; last_busy = b0.busy;
    end
    sclr = rst; tx_valid = iv; tx_data = id; rx_req = ir; result = res;
    if (rec && b0.tx_ready && iv && !rst) n_acc++;
    for (int k = 0; k < NI; k++) model(k, rst, iv, id, ir, res);
    if (rst) armed = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), 1'b0, W'($urandom));
  endtask

  initial begin
    logic [W-1:0] beats [3];
    int           run;
    logic         riv, rir;
    sclr = 1'b1; tx_valid = 1'b0; rx_req = 1'b0; tx_data = '0; result = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Three-beat transmit burst straight from reset: no turnaround.
    rec_start();
    step(0, 1, 8'h11, 0, 8'h00);
    step(0, 1, 8'h11, 0, 8'h00);
    step(0, 1, 8'h22, 0, 8'h00);
    step(0, 1, 8'h33, 0, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00);
    beats = '{8'h11, 8'h22, 8'h33};
    chk("tx.beats", n_acc, 3);
    chk("tx.dt_cycles", cap_dt.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("tx.data%0d", i), 32'(cap_dt[i]), 32'(beats[i]));

    // Two reads after the burst: one IDLE, one TURN, four enabletr cycles.
    rec_start();
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, i < 4, W'(8'hA0 + i));
    chk("rx.enabletr_cycles", n_tr, 4);
    chk("rx.pulses", cap_rx.size(), 2);
    chk("rx.data0", 32'(cap_rx[0]), 32'h A4);
    chk("rx.data1", 32'(cap_rx[1]), 32'h A5);

    // Simultaneous requests from reset: TX first, RX only after TX drains.
    step(1, 0, 0, 0, 0);
    rec_start();
    step(0, 1, 8'h55, 1, 8'h01);
    step(0, 1, 8'h55, 1, 8'h02);
    step(0, 1, 8'h66, 1, 8'h03);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, W'(8'h10 + i));
    idle(8);
    chk("arb.beats", n_acc, 2);
    chk("arb.order", 32'((last_dt >= 0) && (first_tr > last_dt)), 32'd1);
    chk("arb.reads", cap_rx.size(), 1);

    // Reset with two reads in flight discards them.
    step(1, 0, 0, 0, 0);
    rec_start();
    step(0, 0, 8'h00, 1, 8'h77);
    step(0, 0, 8'h00, 1, 8'h78);
    step(0, 0, 8'h00, 1, 8'h79);
    step(1, 0, 8'h00, 0, 8'h7A);
    step(0, 0, 8'h00, 0, 8'h7B);
    chk("rst.enabletr", 32'(last_tr), 32'd0);
    chk("rst.busy", 32'(last_busy), 32'd0);
    idle(10);
    chk("rst.no_rx_valid", cap_rx.size(), 0);
    rec = 1'b0;

    // Bursty random traffic with occasional resets.
    run = 0; riv = 1'b0; rir = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (run == 0) begin
        run = $urandom_range(1, 6);
        riv = ($urandom_range(0, 2) == 0);
        rir = ($urandom_range(0, 1) == 1);
      end
      run--;
      step($urandom_range(0, 299) == 0, riv, W'($urandom), rir, W'($urandom));
    end
    @(negedge clk);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lpm_bustri_seq.md
LPM_BUSTRI_SEQ -- requirements
Module: lpm_bustri_seq

Interface
REQ-001 Parameter lpm_width, default 8: width of the transmit, receive and bus data paths.
REQ-002 Parameter lpm_type, default "lpm_bustri_seq": type identifier string, no functional effect.
REQ-003 Parameter lpm_hint, default "UNUSED": tool hint string, no functional effect.
REQ-004 Parameter lpm_turnaround, default 1, range 0..15: cycles spent in TURN on every direction change.
REQ-005 Parameter lpm_rdlatency, default 2, range 1..8: cycles from read issue to read data sample.
REQ-006 The block SHALL have one clock, clock; reset sclr is synchronous and active-high.
REQ-007 clock  input  1  rising-edge clock for all state.
REQ-008 sclr  input  1  synchronous active-high reset.
REQ-009 tx_valid  input  1  transmit beat offered on tx_data.
REQ-010 tx_data  input  lpm_width  transmit beat.
REQ-011 tx_ready  output  1  beat accepted when tx_valid & tx_ready.
REQ-012 rx_req  input  1  one read issued per cycle while high and accepted.
REQ-013 rx_valid  output  1  one-cycle pulse, rx_data holds one read result.
REQ-014 rx_data  output  lpm_width  read result.
REQ-015 enabledt  output  1  tri-state buffer drive enable, registered.
REQ-016 enabletr  output  1  tri-state buffer receive enable, registered.
REQ-017 data  output  lpm_width  value to drive onto the bus, registered.
REQ-018 result  input  lpm_width  value received from the bus.
REQ-019 busy  output  1  high when state != IDLE, either enable is high, or reads are pending.

Function
REQ-020 The FSM SHALL have four states (IDLE, TX, TURN, RX) and a last-direction register lastdir (NONE, TX, RX).
REQ-021 IDLE: tx_valid has priority over rx_req.
REQ-022 From IDLE with the winning request in the same direction as lastdir, or with lastdir=NONE, the FSM SHALL go directly to TX or RX.
REQ-023 From IDLE with the winning request in the opposite direction to lastdir, the FSM SHALL go to TURN for exactly lpm_turnaround cycles, then to the target state.
REQ-024 With lpm_turnaround=0, TURN SHALL be skipped.
REQ-025 tx_ready SHALL equal (state==TX).
REQ-026 On each accepted beat, data SHALL load tx_data and enabledt SHALL be 1 in the following cycle.
REQ-027 In any cycle without an accepted beat, the next-cycle enabledt SHALL be 0 and data SHALL hold.
REQ-028 TX: tx_valid=0 SHALL cause a transition to IDLE and set lastdir=TX.
REQ-029 TX: rx_req SHALL be ignored while tx_valid remains high.
REQ-030 RX: each cycle with rx_req=1 SHALL issue one read into an lpm_rdlatency-deep valid pipeline.
REQ-031 When a read reaches the pipeline end, rx_valid SHALL pulse and rx_data SHALL load result on that edge.
REQ-032 enabletr SHALL be 1 in every cycle where state==RX.
REQ-033 RX SHALL exit to IDLE (lastdir=RX) only when rx_req=0 and the pipeline is empty, so enabletr stays high until the last sample.
REQ-034 TURN: enabledt and enabletr SHALL both be 0 and tx_ready SHALL be 0.
REQ-035 TURN: requests SHALL be held off and the target direction SHALL be latched on TURN entry.
REQ-036 enabledt and enabletr SHALL never be 1 in the same cycle; bus loopback mode is prohibited.
REQ-037 rx_data SHALL hold its value between rx_valid pulses.

Reset
REQ-038 sclr=1 at any edge SHALL force: state=IDLE, lastdir=NONE, enabledt=0, enabletr=0, data=0, rx_data=0, rx_valid=0, busy=0, and the read pipeline cleared.
REQ-039 Reads pending when sclr asserts SHALL be discarded and produce no rx_valid pulse.
REQ-040 sclr SHALL take priority over all requests in the same cycle.

Verification
REQ-041 Reset then tx_valid held for 3 beats (0x11, 0x22, 0x33) -> tx_ready high 3 cycles; enabledt=1 for 3 consecutive cycles with data 0x11, 0x22, 0x33; no TURN.
REQ-042 After the TX burst, rx_req for 2 cycles with lpm_turnaround=1 and lpm_rdlatency=2 -> 1 IDLE cycle, 1 TURN cycle with both enables 0, enabletr high 4 cycles, 2 rx_valid pulses carrying the result values at the sample edges.
REQ-043 tx_valid and rx_req rise in the same cycle from IDLE with lastdir=NONE -> TX served first; RX entered via TURN only after tx_valid drops.
REQ-044 sclr asserted while 2 reads are pending in RX -> next cycle enabletr=0, busy=0; no rx_valid ever follows.
REQ-045 lpm_turnaround=0, alternating single TX and RX requests -> no TURN cycles; the assertion enabledt & enabletr == 0 holds across a 10k-cycle random run.
